// File: rtl/tanh_grad_pla_if.sv
// Handshake bundle for the tanh gradient unit: y/dy request side and dx response side.
interface tanh_grad_pla_if #(
  parameter int W_Y = 8,
  parameter int W_G = 12
);
  logic           in_valid;
  logic           in_ready;
  logic [W_Y-1:0] y_in;
  logic [W_G-1:0] dy_in;
  logic           out_valid;
  logic           out_ready;
  logic [W_G-1:0] dx_out;

  modport master (
    output in_valid, y_in, dy_in, out_ready,
    input  in_ready, out_valid, dx_out
  );

  modport slave (
    input  in_valid, y_in, dy_in, out_ready,
    output in_ready, out_valid, dx_out
  );
endinterface

// File: rtl/tanh_grad_pla.sv
// dx = dy * (1 - y^2) for the LSTM backward pass, computed over two cycles
// through one shared signed multiplier (y*y first, then dy*(1-y^2)).
module tanh_grad_pla #(
  parameter int W_Y = 8,
  parameter int W_G = 12,
  parameter int G_I = 5
) (
  input  logic           clock,
  input  logic           reset,
  tanh_grad_pla_if.slave bus
);
  localparam int FB = 2 * (W_Y - 1);
  localparam int WS = 2 * W_Y;
  localparam int WP = W_G + WS;
  localparam logic [WS-1:0] ONE = {{(WS-1){1'b0}}, 1'b1} << FB;
  localparam logic [31:0] GI_VEC = 32'(G_I);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQ   = 2'd1;
  localparam logic [1:0] SC   = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W_Y-1:0] y_q, y_d;
  logic [W_G-1:0] dy_q, dy_d;
  logic [WS-1:0]  sq_q, sq_d;
  logic [W_G-1:0] dx_q, dx_d;

  logic signed [W_G-1:0] mul_a;
  logic signed [WS-1:0]  mul_b;
  logic signed [WP-1:0]  mul_a_ext, mul_b_ext, mul_p;
  logic                  unused_bits;

  // Operand select for the single multiplier; d = 1.0 - y^2 never exceeds
  // 2^FB, so it stays positive when read as a WS-bit signed value.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state_q == SQ) begin
      mul_a = {{(W_G-W_Y){y_q[W_Y-1]}}, y_q};
      mul_b = {{W_Y{y_q[W_Y-1]}}, y_q};
    end else if (state_q == SC) begin
      mul_a = dy_q;
      mul_b = ONE - sq_q;
    end
  end

  assign mul_a_ext = {{WS{mul_a[W_G-1]}}, mul_a};
  assign mul_b_ext = {{W_G{mul_b[WS-1]}}, mul_b};
  assign mul_p     = mul_a_ext * mul_b_ext;

  assign unused_bits = ^{mul_p[WP-1:FB+W_G], GI_VEC};

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    dy_d    = dy_q;
    sq_d    = sq_q;
    dx_d    = dx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          y_d     = bus.y_in;
          dy_d    = bus.dy_in;
          state_d = SQ;
        end
      end
      SQ: begin
        sq_d    = mul_p[WS-1:0];
        state_d = SC;
      end
      SC: begin
        // Taking bits above FB is an arithmetic shift right with floor rounding.
        dx_d    = mul_p[FB+W_G-1:FB];
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      dy_q    <= '0;
      sq_q    <= '0;
      dx_q    <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      dy_q    <= dy_d;
      sq_q    <= sq_d;
      dx_q    <= dx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.dx_out    = dx_q;
endmodule

// File: tb/tb_tanh_grad_pla.sv
// Directed and randomised checks of tanh_grad_pla against hand-computed
// values and a floor-rounding reference of dx = dy * (1 - y^2).
module tb_tanh_grad_pla;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tanh_grad_pla_if #(.W_Y(8), .W_G(12)) bus ();

  tanh_grad_pla #(.W_Y(8), .W_G(12), .G_I(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%0h", tag, got);
    end
  endtask

  function automatic logic [11:0] ref_dx(input logic [7:0] y, input logic [11:0] dy);
    int ys, dys, p;
    logic [31:0] r;
    ys  = int'($signed(y));
    dys = int'($signed(dy));
    p   = dys * (16384 - ys * ys);
    r   = 32'(p >>> 14);
    return r[11:0];
  endfunction

  // Full transaction with out_ready already high: accept, SQ, SC, OUT, back to IDLE.
  task automatic run_txn(input string tag, input logic [7:0] y, input logic [11:0] dy,
                         input logic [11:0] exp);
    @(negedge clock);
    bus.y_in = y; bus.dy_in = dy; bus.in_valid = 1'b1;
    chk({tag, "_acc_rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk({tag, "_sq_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_sq_vld"}, 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_sc_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_sc_vld"}, 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_out_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_out_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_dx"}, 32'(bus.dx_out), 32'(exp));
    @(negedge clock);
    chk({tag, "_done_vld"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_done_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [11:0] held_dx;
    logic        stale;
    logic        seen;
    logic [11:0] exp_q[$];
    logic [11:0] exp_v;
    int          sent, got, gap;
    logic        pending;

    bus.in_valid = 1'b0; bus.y_in = '0; bus.dy_in = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dx", 32'(bus.dx_out), 32'd0);
    reset = 1'b0;

    run_txn("y0_dy1",     8'h00, 12'h080, 12'h080);
    run_txn("yhalf_dy1",  8'h40, 12'h080, 12'h060);
    run_txn("yhalf_dym1", 8'h40, 12'hF80, 12'hFA0);
    run_txn("ym1_dymax",  8'h80, 12'h7FF, 12'h000);
    run_txn("ymax_dymax", 8'h7F, 12'h7FF, 12'h01F);
    run_txn("ymax_floor", 8'h7F, 12'hFFF, 12'hFFF);

    // Backpressure: first result stalls 10 cycles while a second pair waits.
    bus.out_ready = 1'b0;
    @(negedge clock);
    bus.y_in = 8'h40; bus.dy_in = 12'h080; bus.in_valid = 1'b1;
    @(negedge clock);
    bus.y_in = 8'h7F; bus.dy_in = 12'h7FF;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      seen = bus.out_valid;
    end
    chk("bp_reach_out", 32'(seen), 32'd1);
    held_dx = bus.dx_out;
    chk("bp_first_dx", 32'(held_dx), 32'h060);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!bus.out_valid || bus.in_ready || bus.dx_out !== held_dx) stale = 1'b1;
    end
    chk("bp_hold_stable", 32'(stale), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_vld", 32'(bus.out_valid), 32'd0);
    chk("bp_release_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("bp_second_acc", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("bp_second_vld", 32'(bus.out_valid), 32'd1);
    chk("bp_second_dx", 32'(bus.dx_out), 32'h01F);
    @(negedge clock);

    // Reset pulse while the unit is in SC discards the transaction.
    @(negedge clock);
    bus.y_in = 8'h00; bus.dy_in = 12'h100; bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_dx", 32'(bus.dx_out), 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus.out_valid || bus.dx_out !== 12'h000) stale = 1'b1;
    end
    chk("mrst_no_stale", 32'(stale), 32'd0);

    // Random pairs with random output stalls, checked in order against the reference.
    sent = 0; got = 0; gap = 0; pending = 1'b0;
    for (int cyc = 0; cyc < 40000 && got < 2000; cyc++) begin
      @(negedge clock);
      if (!pending && sent < 2000) begin
        if (gap == 0) begin
          bus.y_in  = 8'($urandom_range(0, 255));
          bus.dy_in = 12'($urandom_range(0, 4095));
          bus.in_valid = 1'b1;
          pending = 1'b1;
          gap = int'($urandom_range(0, 3));
        end else begin
          gap--;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_out", 32'(bus.dx_out), 32'hFFFF_FFFF);
        end else begin
          exp_v = exp_q.pop_front();
          chk($sformatf("rnd_%0d", got), 32'(bus.dx_out), 32'(exp_v));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_dx(bus.y_in, bus.dy_in));
        sent++;
        pending = 1'b0;
      end
      @(posedge clock);
      #1;
      if (!pending) bus.in_valid = 1'b0;
    end
    chk("rnd_count", 32'(got), 32'd2000);
    chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
